sound_event_scheduler: RTL
==========================

// Module: sound_event_scheduler
// PURPOSE
//  Arbitrates one-cycle sound requests from the pong game logic (score, paddle hit, wall hit, serve)
//  onto the single speaker. Sequences tone/duration/gap per event and drives SpeakerOut via a
//  square-wave tone generator. Sits between game core and speaker pin; all inputs synchronous to CLK.
// PARAMETERS
//  TICK_CYCLES   100000  CLK cycles per 1 ms duration tick (100 MHz system clock)
//  DUR_SCORE_MS  150     duration of each of the two score notes, ticks
//  DUR_PADDLE_MS 50      paddle tone duration, ticks
//  DUR_WALL_MS   30      wall tone duration, ticks
//  DUR_SERVE_MS  80      serve tone duration, ticks
//  GAP_MS        10      silence after every event, ticks
//  HP_SCORE1     95557   half-period in CLK cycles, score note 1 (523 Hz)
//  HP_SCORE2     63776   half-period, score note 2 (784 Hz)
//  HP_PADDLE     113636  half-period, paddle (440 Hz)
//  HP_WALL       227272  half-period, wall (220 Hz)
//  HP_SERVE      75843   half-period, serve (659 Hz)
// PORTS
//  CLK        in   1  system clock, 100 MHz
//  RESET      in   1  asynchronous, active-low reset
//  Score      in   1  score event pulse (priority 3, highest)
//  HitPaddle  in   1  paddle hit pulse (priority 2)
//  HitWall    in   1  wall hit pulse (priority 1)
//  Serve      in   1  serve pulse (priority 0, lowest)
//  Mute       in   1  1 = force SpeakerOut low; sequencing unaffected
//  SpeakerOut out  1  square-wave speaker drive
//  Busy       out  1  1 while state != IDLE
//  ActiveSrc  out  2  source code being played (3 score,2 paddle,1 wall,0 serve); 0 when !Busy
// BEHAVIOUR
//  Reset (RESET=0, immediate): pending=0, state=IDLE, all counters 0, SpeakerOut=0, Busy=0, ActiveSrc=0.
//  Pending: one flag per source, set on edge where its input=1; held until granted. Repeat pulses coalesce.
//   Set and clear of same flag on one edge -> set wins (flag stays 1).
//  States: IDLE, NOTE1, NOTE2, GAP.
//   IDLE: any pending -> grant highest-priority pending on next edge: clear its flag, load cur_src,
//    enter NOTE1, restart prescaler and duration counter, load tone half-period. Request at edge k
//    -> Busy=1 after edge k+1 (2-cycle latency).
//   NOTE1: on duration expiry -> NOTE2 if cur_src=score (HP_SCORE2, DUR_SCORE_MS) else GAP.
//   NOTE2: on expiry -> GAP. GAP: tone off; on expiry -> IDLE (pending re-arbitrated next edge).
//   Preemption: in NOTE1/NOTE2/GAP, pending source with strictly higher priority than cur_src ->
//    next edge: grant it, enter NOTE1, counters and tone phase reset. Equal/lower waits for IDLE.
//  Duration: prescaler counts 0..TICK_CYCLES-1, wraps emitting tick; duration counter counts ticks;
//   expiry when count==DUR-1 and tick. Each tone lasts exactly DUR*TICK_CYCLES cycles.
//  Tone generator: counter 0..HP-1; SpeakerOut toggles when counter==HP-1. On load (state entry or
//   preempt) counter=0, output=0. In IDLE/GAP output held 0. Mute gates output to 0 combinationally.
//  Widths: prescaler 17 b, duration 8 b, half-period 18 b; parameters must fit (no width growth).
// STRUCTURE
//  Package pong_sound_pkg: state enum, source codes (SRC_SERVE..SRC_SCORE), counter width constants.
//  Sub-module tone_gen (CLK, RESET, load, en, half_period[17:0], wave): half-period counter + toggle FF.
//  Top: pending flags, priority encoder, FSM, prescaler, duration counter.
// TESTING (bench overrides TICK_CYCLES=10, DUR_*=4, GAP_MS=2, HP_*=3/5/7/9/11)
//  1 RESET low mid-tone -> SpeakerOut, Busy, ActiveSrc 0 same cycle; after release stays IDLE.
//  2 HitWall pulse edge 0 -> Busy=1,ActiveSrc=1 after edge 1; 40 cycles tone, 20 gap, Busy=0 at 61.
//  3 Score pulse -> two notes of 40 cycles, SpeakerOut period 2*HP_SCORE1 then 2*HP_SCORE2, then gap.
//  4 Serve playing, HitPaddle pulse -> preempt next edge, ActiveSrc=2, SpeakerOut restarts at 0.
//  5 HitWall and Serve same edge -> wall plays first, serve granted 1 cycle after wall's gap ends.
//  6 Mute=1 during paddle tone -> SpeakerOut=0, Busy/ActiveSrc timing identical to unmuted run.

Source files
------------

// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and widths for the pong sound event scheduler.
package pong_sound_pkg;

  localparam int unsigned PRESC_W = 17;
  localparam int unsigned DUR_W   = 8;
  localparam int unsigned HP_W    = 18;
  localparam int unsigned NUM_SRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NOTE1 = 2'd1,
    ST_NOTE2 = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Source code doubles as its arbitration priority.
  typedef enum logic [1:0] {
    SRC_SERVE  = 2'd0,
    SRC_WALL   = 2'd1,
    SRC_PADDLE = 2'd2,
    SRC_SCORE  = 2'd3
  } src_e;

  // Highest-priority pending source; only meaningful when any bit is set.
  function automatic src_e top_src(input logic [NUM_SRC-1:0] pend);
    if (pend[3])      return SRC_SCORE;
    else if (pend[2]) return SRC_PADDLE;
    else if (pend[1]) return SRC_WALL;
    else              return SRC_SERVE;
  endfunction

endpackage

// File: rtl/sound_event_scheduler_tone_gen.sv
// Square-wave generator: toggles every half_period cycles while enabled.
module tone_gen
  import pong_sound_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] r_cnt;
  logic            r_wave;

  // Half-period counter and toggle flop; load or disable restarts phase at 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (load || !en) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (r_cnt == half_period - HP_W'(1)) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + HP_W'(1);
    end
  end

  assign wave = r_wave;

endmodule

// File: rtl/sound_event_scheduler.sv
// Arbitrates pong sound requests onto one speaker with tone/duration/gap sequencing.
module sound_event_scheduler
  import pong_sound_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = 100000,
  parameter int unsigned DUR_SCORE_MS  = 150,
  parameter int unsigned DUR_PADDLE_MS = 50,
  parameter int unsigned DUR_WALL_MS   = 30,
  parameter int unsigned DUR_SERVE_MS  = 80,
  parameter int unsigned GAP_MS        = 10,
  parameter int unsigned HP_SCORE1     = 95557,
  parameter int unsigned HP_SCORE2     = 63776,
  parameter int unsigned HP_PADDLE     = 113636,
  parameter int unsigned HP_WALL       = 227272,
  parameter int unsigned HP_SERVE      = 75843
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Score,
  input  logic       HitPaddle,
  input  logic       HitWall,
  input  logic       Serve,
  input  logic       Mute,
  output logic       SpeakerOut,
  output logic       Busy,
  output logic [1:0] ActiveSrc
);

  state_e               r_state;
  state_e               w_next_state;
  src_e                 r_cur_src;
  src_e                 w_top;
  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   w_req;
  logic [NUM_SRC-1:0]   w_clr;
  logic [PRESC_W-1:0]   r_presc;
  logic [DUR_W-1:0]     r_dur;
  logic [DUR_W-1:0]     w_dur_last;
  logic [HP_W-1:0]      r_hp;
  logic                 w_any;
  logic                 w_preempt;
  logic                 w_tick;
  logic                 w_expire;
  logic                 w_grant;
  logic                 w_load;
  logic                 w_tone_en;
  logic                 w_wave;

  assign w_req     = {Score, HitPaddle, HitWall, Serve};
  assign w_any     = |r_pending;
  assign w_top     = top_src(r_pending);
  assign w_preempt = w_any && (2'(w_top) > 2'(r_cur_src));
  assign w_tick    = (r_presc == PRESC_W'(TICK_CYCLES - 1));
  assign w_expire  = w_tick && (r_dur == w_dur_last);

  // Last duration-tick index of the phase currently playing.
  always_comb begin
    w_dur_last = '0;
    unique case (r_state)
      ST_NOTE1: begin
        unique case (r_cur_src)
          SRC_SCORE:  w_dur_last = DUR_W'(DUR_SCORE_MS - 1);
          SRC_PADDLE: w_dur_last = DUR_W'(DUR_PADDLE_MS - 1);
          SRC_WALL:   w_dur_last = DUR_W'(DUR_WALL_MS - 1);
          default:    w_dur_last = DUR_W'(DUR_SERVE_MS - 1);
        endcase
      end
      ST_NOTE2: w_dur_last = DUR_W'(DUR_SCORE_MS - 1);
      ST_GAP:   w_dur_last = DUR_W'(GAP_MS - 1);
      default:  w_dur_last = '0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: grant from idle, strict-priority preemption, phase expiry.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant      = 1'b1;
          w_next_state = ST_NOTE1;
        end
      end
      ST_NOTE1: begin
        if (w_preempt) begin
          w_grant      = 1'b1;
          w_next_state = ST_NOTE1;
        end else if (w_expire) begin
          w_next_state = (r_cur_src == SRC_SCORE) ? ST_NOTE2 : ST_GAP;
        end
      end
      ST_NOTE2: begin
        if (w_preempt) begin
          w_grant      = 1'b1;
          w_next_state = ST_NOTE1;
        end else if (w_expire) begin
          w_next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_preempt) begin
          w_grant      = 1'b1;
          w_next_state = ST_NOTE1;
        end else if (w_expire) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Any phase entry (including preempt into NOTE1) restarts timing and tone phase.
  assign w_load    = w_grant || (w_next_state != r_state);
  assign w_clr     = w_grant ? (NUM_SRC'(1) << w_top) : '0;
  assign w_tone_en = (r_state == ST_NOTE1) || (r_state == ST_NOTE2);

  // Pending flags: new requests win over a same-edge grant clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_req;
  end

  // Current source and tone half-period for the phase being entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cur_src <= SRC_SERVE;
      r_hp      <= '0;
    end else if (w_grant) begin
      r_cur_src <= w_top;
      unique case (w_top)
        SRC_SCORE:  r_hp <= HP_W'(HP_SCORE1);
        SRC_PADDLE: r_hp <= HP_W'(HP_PADDLE);
        SRC_WALL:   r_hp <= HP_W'(HP_WALL);
        default:    r_hp <= HP_W'(HP_SERVE);
      endcase
    end else if (w_load && (w_next_state == ST_NOTE2)) begin
      r_hp <= HP_W'(HP_SCORE2);
    end
  end

  // Millisecond prescaler and duration counter; idle holds both at zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_presc <= '0;
      r_dur   <= '0;
    end else if (w_load || (r_state == ST_IDLE)) begin
      r_presc <= '0;
      r_dur   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_dur   <= r_dur + DUR_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  tone_gen u_tone_gen (
    .CLK         (CLK),
    .RESET       (RESET),
    .load        (w_load),
    .en          (w_tone_en),
    .half_period (r_hp),
    .wave        (w_wave)
  );

  assign SpeakerOut = w_wave & ~Mute;
  assign Busy       = (r_state != ST_IDLE);
  assign ActiveSrc  = Busy ? 2'(r_cur_src) : 2'd0;

endmodule
